// File: rtl/qddc_if.sv
// rtl/qddc_if.sv - host config, DDC control and sample stream bundle for qddc_ctrl
interface qddc_if #(
  parameter int FSZ   = 26,
  parameter int OSZ   = 16,
  parameter int CNT_W = 16
);
  logic             cfg_wr;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic             commit;
  logic             ddc_reset;
  logic [FSZ-1:0]   ddc_lo_freq;
  logic             ddc_lo_ns_en;
  logic             ddc_iq_swap;
  logic             ddc_out_valid;
  logic [OSZ-1:0]   ddc_out_i;
  logic [OSZ-1:0]   ddc_out_q;
  logic             out_valid;
  logic [OSZ-1:0]   out_i;
  logic [OSZ-1:0]   out_q;
  logic             busy;
  logic [CNT_W-1:0] retune_count;

  // Controller side
  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, commit,
    input  ddc_out_valid, ddc_out_i, ddc_out_q,
    output ddc_reset, ddc_lo_freq, ddc_lo_ns_en, ddc_iq_swap,
    output out_valid, out_i, out_q, busy, retune_count
  );

  // Host plus DDC side
  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, commit,
    output ddc_out_valid, ddc_out_i, ddc_out_q,
    input  ddc_reset, ddc_lo_freq, ddc_lo_ns_en, ddc_iq_swap,
    input  out_valid, out_i, out_q, busy, retune_count
  );
endinterface

// File: rtl/qddc_ctrl.sv
// rtl/qddc_ctrl.sv - shadow/commit configuration and flush sequencing for the quadrature DDC
module qddc_ctrl #(
  parameter int FSZ            = 26,
  parameter int OSZ            = 16,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 8,
  parameter int CNT_W          = 16
) (
  input  logic   clk,
  input  logic   reset,
  qddc_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_SAMPLES);

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic             pending_q, pending_d;
  logic [FSZ-1:0]   lo_sh_q, lo_sh_d;
  logic             ns_sh_q, ns_sh_d;
  logic             swap_sh_q, swap_sh_d;
  logic             flush_sh_q, flush_sh_d;
  logic [FSZ-1:0]   lo_act_q, lo_act_d;
  logic             ns_act_q, ns_act_d;
  logic             swap_act_q, swap_act_d;
  logic [CNT_W-1:0] retune_q, retune_d;
  logic             ddc_reset_q, ddc_reset_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [OSZ-1:0]   out_i_q, out_i_d;
  logic [OSZ-1:0]   out_q_q, out_q_d;

  // Upper write-data bits beyond the tuning word and ctrl fields carry nothing
  logic unused_wdata;
  assign unused_wdata = ^bus.cfg_wdata;

  // Next-state: shadow writes, commit application, flush/settle sequencing and stream gating
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    scnt_d      = scnt_q;
    pending_d   = pending_q;
    lo_sh_d     = lo_sh_q;
    ns_sh_d     = ns_sh_q;
    swap_sh_d   = swap_sh_q;
    flush_sh_d  = flush_sh_q;
    lo_act_d    = lo_act_q;
    ns_act_d    = ns_act_q;
    swap_act_d  = swap_act_q;
    retune_d    = retune_q;
    out_valid_d = 1'b0;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;

    // Shadow writes land at the same edge a commit samples the old shadow values
    if (bus.cfg_wr) begin
      case (bus.cfg_addr)
        2'd0: lo_sh_d = bus.cfg_wdata[FSZ-1:0];
        2'd1: begin
          ns_sh_d    = bus.cfg_wdata[0];
          swap_sh_d  = bus.cfg_wdata[1];
          flush_sh_d = bus.cfg_wdata[2];
        end
        default: ;
      endcase
    end

    case (state_q)
      RUN: begin
        if (bus.ddc_out_valid) begin
          out_valid_d = 1'b1;
          out_i_d     = bus.ddc_out_i;
          out_q_d     = bus.ddc_out_q;
        end
        // A commit that arrived while sequencing is replayed here, merged into one
        if (bus.commit || pending_q) begin
          pending_d  = 1'b0;
          lo_act_d   = lo_sh_q;
          ns_act_d   = ns_sh_q;
          swap_act_d = swap_sh_q;
          retune_d   = retune_q + CNT_W'(1);
          if (flush_sh_q) begin
            state_d = FLUSH;
            fcnt_d  = '0;
          end
        end
      end
      FLUSH: begin
        if (bus.commit) pending_d = 1'b1;
        if (fcnt_q == FLUSH_LAST) begin
          scnt_d  = SETTLE_INIT;
          state_d = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      SETTLE: begin
        if (bus.commit) pending_d = 1'b1;
        if (bus.ddc_out_valid) begin
          scnt_d = scnt_q - SW'(1);
          if (scnt_q == SW'(1)) state_d = RUN;
        end
      end
      default: begin
        state_d = FLUSH;
        fcnt_d  = '0;
      end
    endcase

    ddc_reset_d = (state_d == FLUSH);
    busy_d      = (state_d != RUN) || pending_d;
  end

  // State and output registers; reset restarts the power-up flush sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FLUSH;
      fcnt_q      <= '0;
      scnt_q      <= '0;
      pending_q   <= 1'b0;
      lo_sh_q     <= '0;
      ns_sh_q     <= 1'b0;
      swap_sh_q   <= 1'b0;
      flush_sh_q  <= 1'b0;
      lo_act_q    <= '0;
      ns_act_q    <= 1'b0;
      swap_act_q  <= 1'b0;
      retune_q    <= '0;
      ddc_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      scnt_q      <= scnt_d;
      pending_q   <= pending_d;
      lo_sh_q     <= lo_sh_d;
      ns_sh_q     <= ns_sh_d;
      swap_sh_q   <= swap_sh_d;
      flush_sh_q  <= flush_sh_d;
      lo_act_q    <= lo_act_d;
      ns_act_q    <= ns_act_d;
      swap_act_q  <= swap_act_d;
      retune_q    <= retune_d;
      ddc_reset_q <= ddc_reset_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  assign bus.ddc_reset    = ddc_reset_q;
  assign bus.ddc_lo_freq  = lo_act_q;
  assign bus.ddc_lo_ns_en = ns_act_q;
  assign bus.ddc_iq_swap  = swap_act_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_i        = out_i_q;
  assign bus.out_q        = out_q_q;
  assign bus.busy         = busy_q;
  assign bus.retune_count = retune_q;

endmodule

// File: tb/tb_qddc_ctrl.sv
// tb/tb_qddc_ctrl.sv - randomized and directed self-checking bench for qddc_ctrl
module tb_qddc_ctrl;
  localparam int FSZ            = 26;
  localparam int OSZ            = 16;
  localparam int FLUSH_CYCLES   = 4;
  localparam int SETTLE_SAMPLES = 8;
  localparam int CNT_W          = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qddc_if #(.FSZ(FSZ), .OSZ(OSZ), .CNT_W(CNT_W)) bus ();

  qddc_ctrl #(
    .FSZ(FSZ), .OSZ(OSZ), .FLUSH_CYCLES(FLUSH_CYCLES),
    .SETTLE_SAMPLES(SETTLE_SAMPLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the DDC is either being reset, settling or running
  typedef enum int {M_RUN, M_FLUSH, M_SETTLE} mode_t;
  mode_t            m_mode;
  int               reset_left;
  int               discard_left;
  bit               m_pend;
  logic [FSZ-1:0]   sh_lo, act_lo;
  bit               sh_ns, sh_swap, sh_flush, act_ns, act_swap;
  logic [CNT_W-1:0] m_retunes;
  bit               m_ov;
  logic [OSZ-1:0]   m_oi, m_oq;

  task automatic model_step();
    bit fwd;
    bit apply;
    fwd   = 1'b0;
    apply = 1'b0;
    if (reset) begin
      m_mode = M_FLUSH; reset_left = FLUSH_CYCLES; discard_left = 0; m_pend = 0;
      sh_lo = '0; sh_ns = 0; sh_swap = 0; sh_flush = 0;
      act_lo = '0; act_ns = 0; act_swap = 0; m_retunes = '0;
      m_ov = 0; m_oi = '0; m_oq = '0;
    end else begin
      case (m_mode)
        M_RUN: begin
          fwd   = bus.ddc_out_valid;
          apply = bus.commit || m_pend;
        end
        M_FLUSH: begin
          if (bus.commit) m_pend = 1;
          reset_left--;
          if (reset_left == 0) begin
            if (SETTLE_SAMPLES == 0) m_mode = M_RUN;
            else begin
              m_mode = M_SETTLE;
              discard_left = SETTLE_SAMPLES;
            end
          end
        end
        default: begin
          if (bus.commit) m_pend = 1;
          if (bus.ddc_out_valid) begin
            discard_left--;
            if (discard_left == 0) m_mode = M_RUN;
          end
        end
      endcase
      if (apply) begin
        act_lo = sh_lo; act_ns = sh_ns; act_swap = sh_swap;
        m_pend = 0;
        m_retunes = m_retunes + 1'b1;
        if (sh_flush) begin
          m_mode = M_FLUSH;
          reset_left = FLUSH_CYCLES;
        end
      end
      m_ov = fwd;
      if (fwd) begin
        m_oi = bus.ddc_out_i;
        m_oq = bus.ddc_out_q;
      end
      if (bus.cfg_wr) begin
        if (bus.cfg_addr == 2'd0) sh_lo = bus.cfg_wdata[FSZ-1:0];
        if (bus.cfg_addr == 2'd1) begin
          sh_ns = bus.cfg_wdata[0]; sh_swap = bus.cfg_wdata[1]; sh_flush = bus.cfg_wdata[2];
        end
      end
    end
  endtask

  task automatic compare_all();
    check("ddc_reset", bus.ddc_reset, m_mode == M_FLUSH);
    check("ddc_lo_freq", bus.ddc_lo_freq, act_lo);
    check("ddc_lo_ns_en", bus.ddc_lo_ns_en, act_ns);
    check("ddc_iq_swap", bus.ddc_iq_swap, act_swap);
    check("out_valid", bus.out_valid, m_ov);
    check("out_i", bus.out_i, m_oi);
    check("out_q", bus.out_q, m_oq);
    check("busy", bus.busy, (m_mode != M_RUN) || m_pend);
    check("retune_count", bus.retune_count, m_retunes);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    bus.cfg_wr        = 1'b0;
    bus.commit        = 1'b0;
    bus.ddc_out_valid = 1'b0;
  endtask

  task automatic sample_in();
    bus.ddc_out_valid = 1'b1;
    bus.ddc_out_i     = OSZ'($urandom);
    bus.ddc_out_q     = OSZ'($urandom);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
  endtask

  // Feeds SETTLE_SAMPLES+1 samples: all but the last must be swallowed
  task automatic settle_run(input string tag);
    logic [OSZ-1:0] last_i;
    for (int k = 1; k <= SETTLE_SAMPLES + 1; k++) begin
      sample_in();
      last_i = bus.ddc_out_i;
      tick();
      if (k <= SETTLE_SAMPLES) begin
        check({tag, "_drop"}, bus.out_valid, 1'b0);
      end else begin
        check({tag, "_fwd_valid"}, bus.out_valid, 1'b1);
        check({tag, "_fwd_data"}, bus.out_i, last_i);
        check({tag, "_fwd_busy"}, bus.busy, 1'b0);
      end
    end
  endtask

  task automatic power_up();
    int hi;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_lo_freq", bus.ddc_lo_freq, '0);
    check("rst_retune", bus.retune_count, '0);
    check("rst_ddc_reset", bus.ddc_reset, 1'b1);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    reset = 1'b0;
    hi = bus.ddc_reset ? 1 : 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.ddc_reset) hi++;
    end
    check("pwrup_ddc_reset_cycles", 64'(hi), 64'(FLUSH_CYCLES));
    settle_run("pwrup");
  endtask

  initial begin
    int hi;
    logic [OSZ-1:0] last_i;
    reset             = 1'b1;
    bus.cfg_wr        = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_wdata     = '0;
    bus.commit        = 1'b0;
    bus.ddc_out_valid = 1'b0;
    bus.ddc_out_i     = '0;
    bus.ddc_out_q     = '0;

    power_up();

    // No-flush retune: stream keeps flowing
    wr(2'd0, 32'h0123456); sample_in(); tick();
    wr(2'd1, 32'h2);       sample_in(); tick();
    bus.commit = 1'b1;     sample_in(); tick();
    check("nf_lo_freq", bus.ddc_lo_freq, 26'h0123456);
    check("nf_iq_swap", bus.ddc_iq_swap, 1'b1);
    check("nf_retune", bus.retune_count, 16'd1);
    check("nf_ddc_reset", bus.ddc_reset, 1'b0);
    check("nf_out_valid", bus.out_valid, 1'b1);

    // Flush retune: sample on the commit edge still forwarded
    wr(2'd1, 32'h4); sample_in(); tick();
    bus.commit = 1'b1; sample_in(); last_i = bus.ddc_out_i; tick();
    check("fl_edge_valid", bus.out_valid, 1'b1);
    check("fl_edge_data", bus.out_i, last_i);
    check("fl_retune", bus.retune_count, 16'd2);
    check("fl_iq_swap", bus.ddc_iq_swap, 1'b0);
    hi = bus.ddc_reset ? 1 : 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.ddc_reset) hi++;
      check("fl_busy", bus.busy, 1'b1);
    end
    check("fl_ddc_reset_cycles", 64'(hi), 64'(FLUSH_CYCLES));
    settle_run("fl");

    // Pending merge: two commits during SETTLE apply once with the newest shadow
    bus.commit = 1'b1; tick();
    repeat (FLUSH_CYCLES) tick();
    repeat (2) begin sample_in(); tick(); end
    wr(2'd0, 32'h10); tick();
    bus.commit = 1'b1; tick();
    wr(2'd0, 32'h20); tick();
    bus.commit = 1'b1; tick();
    check("pm_retune_mid", bus.retune_count, 16'd3);
    check("pm_busy_mid", bus.busy, 1'b1);
    repeat (40) begin sample_in(); tick(); end
    check("pm_lo_freq", bus.ddc_lo_freq, 26'h20);
    check("pm_retune", bus.retune_count, 16'd4);
    check("pm_busy", bus.busy, 1'b0);

    // Same-cycle write and commit
    wr(2'd1, 32'h0); tick();
    wr(2'd0, 32'h5); tick();
    wr(2'd0, 32'h9); bus.commit = 1'b1; tick();
    check("sc_first", bus.ddc_lo_freq, 26'h5);
    bus.commit = 1'b1; tick();
    check("sc_second", bus.ddc_lo_freq, 26'h9);
    check("sc_retune", bus.retune_count, 16'd6);

    // Reset during SETTLE with a pending commit
    wr(2'd1, 32'h4); tick();
    bus.commit = 1'b1; tick();
    repeat (FLUSH_CYCLES) tick();
    repeat (3) begin sample_in(); tick(); end
    bus.commit = 1'b1; tick();
    check("rs_pending_busy", bus.busy, 1'b1);
    power_up();
    repeat (10) begin sample_in(); tick(); end
    check("rs_no_pending_busy", bus.busy, 1'b0);
    check("rs_no_pending_retune", bus.retune_count, 16'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1) sample_in();
      if ($urandom_range(0, 19) == 0) bus.commit = 1'b1;
      if ($urandom_range(0, 7) == 0) wr(2'($urandom_range(0, 3)), $urandom);
      tick();
    end
    reset = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
